prbs_checker: RTL and testbench

PRBS_CHECKER -- requirements
Module: prbs_checker

---
 rtl/prbs_pkg.sv | 27 ++
 rtl/prbs_lfsr.sv | 30 +++
 rtl/prbs_checker.sv | 136 +++++++++++++
 tb/tb_prbs_checker.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared types and helpers for the PRBS checker: FSM states, ORDER->TAP lookup
// and the set of supported PRBS orders.
package prbs_pkg;

  typedef enum logic {
    HUNT  = 1'b0,
    CHECK = 1'b1
  } state_t;

  // Bit n set means PRBS order n is supported (7, 15, 23, 31).
  localparam logic [31:0] LEGAL_ORDER_MASK = 32'h8080_8080;

  function automatic logic order_legal(input int order);
    return (order inside {[0:31]}) && LEGAL_ORDER_MASK[order[4:0]];
  endfunction

  function automatic int tap_of(input int order);
    case (order)
      7:       return 6;
      15:      return 14;
      23:      return 18;
      31:      return 28;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// History register with PRBS prediction; shifts in either the received bit
// (hunting) or its own prediction (free-running generator once locked).
module prbs_lfsr
  import prbs_pkg::*;
#(
  parameter int ORDER = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic load_din,
  input  logic din,
  output logic pred
);

  localparam int TAP = tap_of(ORDER);

  logic [ORDER-1:0] sr;

  assign pred = sr[ORDER-1] ^ sr[TAP-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else if (en) begin
      sr <= {sr[ORDER-2:0], (load_din ? din : pred)};
    end
  end

endmodule

// File: rtl/prbs_checker.sv
// PRBS checker: HUNT/CHECK lock FSM with windowed loss-of-sync detection.
// Optional saturating error total enabled by defining PRBS_CHK_TOTAL_EN.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int ORDER    = 15,
  parameter int LOCK_LEN = 32,
  parameter int LOS_WIN  = 64,
  parameter int LOS_THR  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  input  logic        din_val,
  input  logic        resync,
  output logic        err,
  output logic        val,
  output logic        locked
`ifdef PRBS_CHK_TOTAL_EN
  ,
  output logic [31:0] err_total
`endif
);

  localparam int FILL_W  = $clog2(ORDER) + 1;
  localparam int MATCH_W = $clog2(LOCK_LEN) + 1;
  localparam int WIN_W   = $clog2(LOS_WIN) + 1;
  localparam int ERR_W   = $clog2(LOS_THR) + 1;

  if (!order_legal(ORDER)) begin : g_bad_order
    $error("prbs_checker: unsupported ORDER %0d", ORDER);
  end

  state_t               state;
  logic [FILL_W-1:0]    fill_cnt;
  logic [MATCH_W-1:0]   match_cnt;
  logic [WIN_W-1:0]     win_cnt;
  logic [ERR_W-1:0]     err_cnt;
  logic                 pred;
  logic                 mismatch;
  logic [ERR_W-1:0]     err_cnt_nxt;

  assign mismatch    = din ^ pred;
  assign err_cnt_nxt = err_cnt + ERR_W'(mismatch);

  prbs_lfsr #(.ORDER(ORDER)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (din_val && !resync),
    .load_din (state == HUNT),
    .din      (din),
    .pred     (pred)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      locked    <= 1'b0;
      err       <= 1'b0;
      val       <= 1'b0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      err_cnt   <= '0;
    end else if (resync) begin
      state     <= HUNT;
      locked    <= 1'b0;
      err       <= 1'b0;
      val       <= 1'b0;
      fill_cnt  <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      err_cnt   <= '0;
    end else if (din_val) begin
      case (state)
        HUNT: begin
          err <= 1'b0;
          val <= 1'b0;
          if (fill_cnt != FILL_W'(ORDER)) begin
            fill_cnt <= fill_cnt + 1'b1;
          end else if (mismatch) begin
            match_cnt <= '0;
          end else if (match_cnt == MATCH_W'(LOCK_LEN - 1)) begin
            state     <= CHECK;
            locked    <= 1'b1;
            match_cnt <= '0;
            win_cnt   <= '0;
            err_cnt   <= '0;
          end else begin
            match_cnt <= match_cnt + 1'b1;
          end
        end
        CHECK: begin
          err <= mismatch;
          val <= 1'b1;
          // Threshold hit wins over the end-of-window clear.
          if (err_cnt_nxt == ERR_W'(LOS_THR)) begin
            state     <= HUNT;
            locked    <= 1'b0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            win_cnt   <= '0;
            err_cnt   <= '0;
          end else if (win_cnt == WIN_W'(LOS_WIN - 1)) begin
            win_cnt <= '0;
            err_cnt <= '0;
          end else begin
            win_cnt <= win_cnt + 1'b1;
            err_cnt <= err_cnt_nxt;
          end
        end
        default: state <= HUNT;
      endcase
    end else begin
      err <= 1'b0;
      val <= 1'b0;
    end
  end

`ifdef PRBS_CHK_TOTAL_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
    return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_total <= '0;
    end else if (resync) begin
      err_total <= '0;
    end else if (val && err) begin
      err_total <= sat_inc(err_total);
    end
  end
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker with default parameters (PRBS15, lock 32,
// window 64, threshold 16); reference stream from x^15+x^14+1.
module tb_prbs_checker;

  logic clk = 1'b0;
  logic rst_n, din, din_val, resync;
  logic err, val, locked;
`ifdef PRBS_CHK_TOTAL_EN
  logic [31:0] err_total;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [14:0] g;

  prbs_checker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_val   (din_val),
    .resync    (resync),
    .err       (err),
    .val       (val),
    .locked    (locked)
`ifdef PRBS_CHK_TOTAL_EN
    ,
    .err_total (err_total)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  // Drive one cycle; valid cycles advance the reference stream.
  task automatic send(input logic v, input logic inv);
    logic b;
    @(negedge clk);
    if (v) begin
      b = g[14] ^ g[13];
      g = {g[13:0], b};
    end else begin
      b = 1'($urandom_range(0, 1));
    end
    din     = b ^ inv;
    din_val = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_lock(input string tag);
    int vbad = 0;
    for (int i = 1; i <= 47; i++) begin
      send(1'b1, 1'b0);
      if (val !== 1'b0) vbad++;
      if (i == 46) begin
        n_cmp++;
        if (locked !== 1'b0) begin
          n_bad++;
          $display("FAIL %s_early: locked=%b after 46 bits, expected 0", tag, locked);
        end
      end
    end
    n_cmp++;
    if (locked !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_lock: locked=%b after 47 bits, expected 1", tag, locked);
    end
    n_cmp++;
    if (vbad != 0) begin
      n_bad++;
      $display("FAIL %s_hunt_val: val=1 seen %0d times while hunting, expected 0", tag, vbad);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; din = 1'b0; din_val = 1'b0; resync = 1'b0;
    g = 15'h1ACE;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: err=%b expected 0", err); end
    n_cmp++;
    if (val !== 1'b0) begin n_bad++; $display("FAIL reset_val: val=%b expected 0", val); end
    n_cmp++;
    if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked: locked=%b expected 0", locked); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lock;
    int bad = 0;
    do_lock("lock");
    send(1'b1, 1'b0);
    n_cmp++;
    if (val !== 1'b1 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL first_check: val=%b err=%b, expected val=1 err=0", val, err);
    end
    for (int i = 0; i < 10000; i++) begin
      send(1'b1, 1'b0);
      if (err !== 1'b0 || val !== 1'b1 || locked !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL clean_run: %0d bad cycles over 10000 bits, expected 0", bad);
    end
  endtask

  task automatic test_single_err;
    int errs = 0;
    send(1'b1, 1'b1);
    n_cmp++;
    if (err !== 1'b1 || val !== 1'b1 || locked !== 1'b1) begin
      n_bad++;
      $display("FAIL single_err: err=%b val=%b locked=%b, expected 1 1 1", err, val, locked);
    end
    for (int i = 0; i < 100; i++) begin
      send(1'b1, 1'b0);
      if (err !== 1'b0 || locked !== 1'b1) errs++;
    end
    n_cmp++;
    if (errs != 0) begin
      n_bad++;
      $display("FAIL single_err_after: %0d bad cycles after the error, expected 0", errs);
    end
  endtask

  // resync asserted together with a valid bit: the bit must be discarded.
  task automatic do_resync(input string tag);
    @(negedge clk);
    resync  = 1'b1;
    din_val = 1'b1;
    din     = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    resync = 1'b0;
    n_cmp++;
    if (val !== 1'b0 || locked !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_resync: val=%b locked=%b, expected 0 0", tag, val, locked);
    end
  endtask

  task automatic test_los;
    int drop = 0;
    do_resync("los");
    do_lock("los_pre");
    for (int p = 0; p < 64; p++) begin
      send(1'b1, (p >= 48));
      if (p < 63 && locked !== 1'b1) drop++;
      if (p == 63) begin
        n_cmp++;
        if (err !== 1'b1 || val !== 1'b1 || locked !== 1'b0) begin
          n_bad++;
          $display("FAIL los_trigger: err=%b val=%b locked=%b, expected 1 1 0", err, val, locked);
        end
      end
    end
    n_cmp++;
    if (drop != 0) begin
      n_bad++;
      $display("FAIL los_early_drop: lost lock %0d times before 16th error, expected 0", drop);
    end
    do_lock("relock");
  endtask

  task automatic test_window15;
    int errs = 0;
    int drop = 0;
    logic inv;
    for (int w = 0; w < 10; w++) begin
      for (int p = 0; p < 64; p++) begin
        inv = (w % 2 == 0) ? (p >= 49) : (p < 15);
        send(1'b1, inv);
        if (err === 1'b1 && val === 1'b1) errs++;
        if (locked !== 1'b1) drop++;
      end
    end
    n_cmp++;
    if (errs != 150) begin
      n_bad++;
      $display("FAIL win15_errs: counted %0d err pulses, expected 150", errs);
    end
    n_cmp++;
    if (drop != 0) begin
      n_bad++;
      $display("FAIL win15_lock: unlocked %0d cycles, expected 0", drop);
    end
  endtask

  task automatic test_toggle;
    int vc = 0;
    int idle_bad = 0;
    int chk_bad = 0;
    do_resync("toggle");
    while (vc < 47) begin
      send(1'b1, 1'b0);
      vc++;
      if (vc == 46) begin
        n_cmp++;
        if (locked !== 1'b0) begin
          n_bad++;
          $display("FAIL toggle_early: locked=%b after 46 valid bits, expected 0", locked);
        end
      end
      if (vc == 47) begin
        n_cmp++;
        if (locked !== 1'b1) begin
          n_bad++;
          $display("FAIL toggle_lock: locked=%b after 47 valid bits, expected 1", locked);
        end
      end
      send(1'b0, 1'b0);
      if (val !== 1'b0) idle_bad++;
    end
    for (int i = 0; i < 20; i++) begin
      send(1'b1, 1'b0);
      if (val !== 1'b1 || err !== 1'b0) chk_bad++;
      send(1'b0, 1'b0);
      if (val !== 1'b0) idle_bad++;
    end
    n_cmp++;
    if (idle_bad != 0) begin
      n_bad++;
      $display("FAIL toggle_idle_val: val=1 after %0d idle cycles, expected 0", idle_bad);
    end
    n_cmp++;
    if (chk_bad != 0) begin
      n_bad++;
      $display("FAIL toggle_check: %0d bad valid cycles, expected 0", chk_bad);
    end
  endtask

  task automatic test_midreset;
    send(1'b1, 1'b1);
    n_cmp++;
    if (err !== 1'b1 || val !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_err: err=%b val=%b, expected 1 1", err, val);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (err !== 1'b0 || val !== 1'b0 || locked !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: err=%b val=%b locked=%b, expected 0 0 0", err, val, locked);
    end
`ifdef PRBS_CHK_TOTAL_EN
    n_cmp++;
    if (err_total !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_total: err_total=%0d expected 0", err_total);
    end
`endif
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_lock("post_reset");
  endtask

  initial begin
    test_reset();
    test_lock();
    test_single_err();
    test_los();
    test_window15();
    test_toggle();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
